airi5c_jtag_master: RTL
=======================

Name: airi5c_jtag_master

Overview:
JTAG TAP controller driver, the initiator side of the JTAG link that airi5c_dtm answers. It accepts scan commands on a valid/ready interface, generates TCK/TMS/TDI, samples TDO and returns the captured bits. It is used on-chip for self-debug and bring-up, and in the SoC bench to drive airi5c_dtm without an external probe.

Parameters:
CLK_DIV, 4, clk cycles per TCK half period; minimum legal value is 4, which covers airi5c_dtm edge-detect latency.
MAX_LEN, 64, maximum shift length in bits.
LEN_W, 7, width of cmd_len; must satisfy 2^LEN_W > MAX_LEN.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
cmd_valid  input  1  command request
cmd_ready  output  1  high only in IDLE
cmd_type  input  2  0=TAP_RESET, 1=SCAN_IR, 2=SCAN_DR, 3=RUN_IDLE
cmd_len  input  LEN_W  shift length for SCAN_*, TCK count for RUN_IDLE
cmd_data  input  MAX_LEN  TDI bits, LSB shifted first
rsp_valid  output  1  one-cycle pulse when command completes
rsp_data  output  MAX_LEN  captured TDO bits, LSB first, unused upper bits zero
busy  output  1  command in progress
tck  output  1  JTAG clock
tms  output  1  JTAG mode select
tdi  output  1  JTAG data to target
tdo  input  1  JTAG data from target, synchronous to clk

Behaviour:
- Reset values: tck=0, tms=1, tdi=0, cmd_ready=1 (the first cycle after reset is deasserted), rsp_valid=0, rsp_data=0, busy=0, FSM=IDLE.
- Reset mid-command aborts immediately with no response. TAP state is then undefined; software issues TAP_RESET.
- Handshake: the command is accepted on cmd_valid & cmd_ready. cmd_* are registered at acceptance. busy=1 from the next cycle until rsp_valid.
- TCK: idles low. Each TCK period is CLK_DIV clk cycles low, then CLK_DIV clk cycles high. The first low phase starts the cycle after acceptance.
- tms/tdi change only on the clk cycle tck falls, or at the start of the first low phase.
- TDO is sampled on the last clk of each low phase, i.e. at the rising-edge instant.
- Length clamp: cmd_len=0 for SCAN_* is treated as 1, and cmd_len>MAX_LEN as MAX_LEN. RUN_IDLE with cmd_len=0 completes with no TCK, rsp_valid 2 cycles after acceptance.
- TMS sequence per TCK, assuming the target starts in Run-Test/Idle:
  TAP_RESET: 1,1,1,1,1,0. Six TCK; ends in Run-Test/Idle.
  SCAN_IR: 1,1,0,0, then L shift TCKs (tms=0, except the last tms=1), then 1,0. Total 6+L TCK.
  SCAN_DR: 1,0,0, then L shift TCKs, then 1,0. Total 5+L TCK.
  RUN_IDLE: N TCK with tms=0.
- During shift TCK i (0-based), tdi=cmd_data[i] and rsp_data[i] takes the sampled tdo. tdi=0 outside the shift phase.
- FSM states: IDLE, HEADER (pre-shift TMS pattern from a small counter), SHIFT (bit counter 0..L-1), TRAILER (Exit1→Update→Idle), RSTSEQ, RUNCNT, DONE.
  IDLE→(accept) HEADER / RSTSEQ / RUNCNT.
  HEADER→SHIFT, SHIFT→TRAILER, TRAILER→DONE, RSTSEQ→DONE, RUNCNT→DONE.
  DONE→IDLE, pulsing rsp_valid for one clk.
- Completion timing: rsp_valid rises at the end of the final TCK period, CLK_DIV clks after the last rising edge, with tck back low. cmd_ready returns the following cycle.
- After completion, tms holds 0 (Run-Test/Idle) until the next command. After reset it holds 1.
- rsp_data holds its value until the next command completes. It is cleared at acceptance.
- Commands presented while busy stall (cmd_ready=0). There is no queueing.

Decomposition:
- airi5c_jtag_master_constants.vh holds: cmd_type codes, FSM state encodings, and header/trailer lengths.
- The TAP state codes already used by airi5c_dtm move to a shared airi5c_jtag_constants.vh, for the bench TAP monitor.
- One sub-module, airi5c_jtag_tck_gen: a divider counter with enable, outputting tck plus single-cycle fall_stb and sample_stb strobes.

Test Plan:
1. DTM partner, clk shared, CLK_DIV=4. TAP_RESET, then SCAN_IR len 5 data 0x10 → rsp_data=0x01 (IR capture value). TAP_RESET takes exactly 6 TCK = 48 clk.
2. After TAP_RESET, SCAN_DR len 32 → rsp_data=0x10001001 (IDCODE). Exactly 37 TCK; rsp_valid 296 clk after acceptance ±1.
3. SCAN_IR 0x10, then SCAN_DR len 32 → rsp_data=0x00002071 (DTM register).
4. SCAN_IR 0x11, then SCAN_DR len 41 with addr 0x10, data 0xA5A5A5A5, op=2 → DTM pulses dmi_en=dmi_wen=1 with dmi_addr=0x10, dmi_wdata=0xA5A5A5A5. A following read scan returns addr 0x10 in bits 40:34.
5. Loopback tdo=tdi: SCAN_DR len 64 data 0xDEADBEEF01234567 → rsp_data equal. len 0 → 1 shift. len 100 → 64 shifts.
6. cmd_valid held during busy → cmd_ready=0 and no second acceptance. Reset asserted mid-SHIFT → next cycle tck=0, tms=1, busy=0, no rsp_valid.

Source files
------------

// File: rtl/airi5c_jtag_master_pkg.sv
// Shared types and constants for the JTAG master: command codes, FSM states,
// and the fixed TMS patterns that walk the TAP between Run-Test/Idle and Shift.
package airi5c_jtag_master_pkg;

  typedef enum logic [1:0] {
    CmdTapReset = 2'd0,
    CmdScanIr   = 2'd1,
    CmdScanDr   = 2'd2,
    CmdRunIdle  = 2'd3
  } cmd_type_e;

  typedef enum logic [2:0] {
    StIdle,
    StHeader,
    StShift,
    StTrailer,
    StRstSeq,
    StRunCnt,
    StDone
  } state_e;

  // TCK counts of the fixed parts of each sequence.
  localparam int unsigned HdrLenIr = 4;
  localparam int unsigned HdrLenDr = 3;
  localparam int unsigned TrlLen   = 2;
  localparam int unsigned RstLen   = 6;

  // Header TMS bits, bit i is driven on header TCK i.
  localparam logic [3:0] HdrTmsIr = 4'b0011;  // Select-DR, Select-IR, Capture-IR, Shift-IR
  localparam logic [3:0] HdrTmsDr = 4'b0001;  // Select-DR, Capture-DR, Shift-DR

  function automatic logic hdr_tms(cmd_type_e t, logic [2:0] idx);
    logic [3:0] pat;
    pat = (t == CmdScanIr) ? HdrTmsIr : HdrTmsDr;
    return (idx < 3'd4) ? pat[idx[1:0]] : 1'b0;
  endfunction

endpackage

// File: rtl/airi5c_jtag_master_if.sv
// Command/response handshake between a scan requester (master) and the
// JTAG master block (slave).
interface airi5c_jtag_master_if #(
  parameter int unsigned MAX_LEN = 64,
  parameter int unsigned LEN_W   = 7
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic [1:0]         cmd_type;
  logic [LEN_W-1:0]   cmd_len;
  logic [MAX_LEN-1:0] cmd_data;
  logic               rsp_valid;
  logic [MAX_LEN-1:0] rsp_data;
  logic               busy;

  modport master (
    output cmd_valid, cmd_type, cmd_len, cmd_data,
    input  cmd_ready, rsp_valid, rsp_data, busy
  );

  modport slave (
    input  cmd_valid, cmd_type, cmd_len, cmd_data,
    output cmd_ready, rsp_valid, rsp_data, busy
  );
endinterface

// File: rtl/airi5c_jtag_master_tck_gen.sv
// TCK divider: CLK_DIV clks low then CLK_DIV clks high while enabled, idle low.
// sample_stb marks the last low clk (TDO sample point), fall_stb the last high clk.
module airi5c_jtag_master_tck_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tck,
  output logic fall_stb,
  output logic sample_stb
);

  localparam int unsigned CntW = $clog2(CLK_DIV);
  localparam logic [CntW-1:0] CntLast = CntW'(CLK_DIV - 1);

  logic [CntW-1:0] cnt_q;
  logic            phase_q;
  logic            last;

  assign last = (cnt_q == CntLast);

  // Half-period counter; disabling restarts at the beginning of a low phase.
  always_ff @(posedge clk) begin
    if (reset || !en) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else if (last) begin
      cnt_q   <= '0;
      phase_q <= ~phase_q;
    end else begin
      cnt_q   <= cnt_q + CntW'(1);
    end
  end

  assign tck        = phase_q;
  assign fall_stb   = en & phase_q & last;
  assign sample_stb = en & ~phase_q & last;

endmodule

// File: rtl/airi5c_jtag_master.sv
// JTAG initiator: runs TAP reset, IR/DR scans and idle clocking on request,
// driving TCK/TMS/TDI and returning the TDO bits captured during the shift.
module airi5c_jtag_master #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned MAX_LEN = 64,
  parameter int unsigned LEN_W   = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  airi5c_jtag_master_if.slave   bus,
  output logic                  tck,
  output logic                  tms,
  output logic                  tdi,
  input  logic                  tdo
);
  import airi5c_jtag_master_pkg::*;

  state_e             state_q, state_d;
  cmd_type_e          type_q, type_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [MAX_LEN-1:0] data_q, data_d;
  logic [MAX_LEN-1:0] rsp_q, rsp_d;
  logic               tms_q, tms_d;
  logic               tdi_q, tdi_d;

  logic               tck_en;
  logic               fall_stb;
  logic               sample_stb;
  logic [LEN_W-1:0]   hdr_last;
  logic [MAX_LEN-1:0] shr;

  assign tck_en = (state_q != StIdle) && (state_q != StDone);

  airi5c_jtag_master_tck_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tck_gen (
    .clk       (clk),
    .reset     (reset),
    .en        (tck_en),
    .tck       (tck),
    .fall_stb  (fall_stb),
    .sample_stb(sample_stb)
  );

  // State and datapath registers; tms idles high after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      type_q  <= CmdTapReset;
      len_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      rsp_q   <= '0;
      tms_q   <= 1'b1;
      tdi_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      rsp_q   <= rsp_d;
      tms_q   <= tms_d;
      tdi_q   <= tdi_d;
    end
  end

  // Sequencer: tms/tdi for the next TCK are loaded at acceptance or on fall_stb,
  // so they change in the same clk that tck goes low.
  always_comb begin
    state_d  = state_q;
    type_d   = type_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    rsp_d    = rsp_q;
    tms_d    = tms_q;
    tdi_d    = tdi_q;
    shr      = '0;
    hdr_last = (type_q == CmdScanIr) ? LEN_W'(HdrLenIr - 1) : LEN_W'(HdrLenDr - 1);

    case (state_q)
      StIdle: begin
        if (bus.cmd_valid) begin
          type_d = cmd_type_e'(bus.cmd_type);
          data_d = bus.cmd_data;
          len_d  = bus.cmd_len;
          rsp_d  = '0;
          cnt_d  = '0;
          tdi_d  = 1'b0;
          tms_d  = 1'b1;
          case (cmd_type_e'(bus.cmd_type))
            CmdTapReset: state_d = StRstSeq;
            CmdScanIr, CmdScanDr: begin
              state_d = StHeader;
              if (bus.cmd_len == '0) begin
                len_d = LEN_W'(1);
              end else if (bus.cmd_len > LEN_W'(MAX_LEN)) begin
                len_d = LEN_W'(MAX_LEN);
              end
            end
            CmdRunIdle: begin
              state_d = StRunCnt;
              tms_d   = 1'b0;
            end
            default: state_d = StIdle;
          endcase
        end
      end

      StHeader: begin
        if (fall_stb) begin
          if (cnt_q == hdr_last) begin
            state_d = StShift;
            cnt_d   = '0;
            tms_d   = (len_q == LEN_W'(1));
            tdi_d   = data_q[0];
          end else begin
            cnt_d = cnt_q + LEN_W'(1);
            tms_d = hdr_tms(type_q, cnt_d[2:0]);
          end
        end
      end

      StShift: begin
        if (sample_stb) begin
          for (int unsigned i = 0; i < MAX_LEN; i++) begin
            if (LEN_W'(i) == cnt_q) rsp_d[i] = tdo;
          end
        end
        if (fall_stb) begin
          if (cnt_q == len_q - LEN_W'(1)) begin
            state_d = StTrailer;
            cnt_d   = '0;
            tms_d   = 1'b1;  // Exit1 -> Update
            tdi_d   = 1'b0;
          end else begin
            cnt_d = cnt_q + LEN_W'(1);
            tms_d = (cnt_d == len_q - LEN_W'(1));  // last shift bit leaves Shift
            shr   = data_q >> cnt_d;
            tdi_d = shr[0];
          end
        end
      end

      StTrailer: begin
        if (fall_stb) begin
          if (cnt_q == LEN_W'(TrlLen - 1)) begin
            state_d = StDone;
          end else begin
            cnt_d = cnt_q + LEN_W'(1);
          end
          tms_d = 1'b0;
        end
      end

      StRstSeq: begin
        if (fall_stb) begin
          if (cnt_q == LEN_W'(RstLen - 1)) begin
            state_d = StDone;
            tms_d   = 1'b0;
          end else begin
            cnt_d = cnt_q + LEN_W'(1);
            tms_d = (cnt_d != LEN_W'(RstLen - 1));
          end
        end
      end

      StRunCnt: begin
        tms_d = 1'b0;
        if (len_q == '0) begin
          state_d = StDone;
        end else if (fall_stb) begin
          if (cnt_q == len_q - LEN_W'(1)) begin
            state_d = StDone;
          end else begin
            cnt_d = cnt_q + LEN_W'(1);
          end
        end
      end

      StDone: begin
        state_d = StIdle;
        tms_d   = 1'b0;
      end

      default: state_d = StIdle;
    endcase
  end

  assign bus.cmd_ready = (state_q == StIdle);
  assign bus.rsp_valid = (state_q == StDone);
  assign bus.rsp_data  = rsp_q;
  assign bus.busy      = tck_en;
  assign tms           = tms_q;
  assign tdi           = tdi_q;

endmodule
